// File: rtl/fence_t_sequencer_if.sv
// Flush/ack channel bundle between the fence.t sequencer and the caches/TLBs.
// Handshake: flush_req_o[i] is a level raised by the sequencer and held until
// the channel answers with a single-cycle flush_ack_i[i] pulse; after the ack
// the request drops on the next cycle and stays low for the rest of the
// sequence. busy_i[i] is a plain level meaning the channel still has an
// external transaction outstanding; it carries no handshake of its own.
interface fence_t_sequencer_if #(
   parameter int unsigned NR_CH = 2
);
   logic [NR_CH-1:0] flush_req_o;
   logic [NR_CH-1:0] flush_ack_i;
   logic [NR_CH-1:0] busy_i;

   modport master (
      output flush_req_o,
      input  flush_ack_i,
      input  busy_i
   );

   modport slave (
      input  flush_req_o,
      output flush_ack_i,
      output busy_i
   );
endinterface

// File: rtl/fence_t_sequencer.sv
// fence.t sequencer: on a committed fence.t it halts commit, flushes every
// channel, waits for outstanding traffic and a timer-relative pad to drain,
// then pulses a microreset and resumes fetch at the instruction after the
// fence. A timeout bounds the flush/drain phases. All outputs are registered.
module fence_t_sequencer #(
   parameter int unsigned NR_CH      = 2,
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned PAD_W      = 32,
   parameter int unsigned TIMEOUT    = 1024,
   // Matches the core's virtual address width (riscv::VLEN on RV64).
   parameter int unsigned VLEN       = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   fence_t_i,
   input  logic [VLEN-1:0]        pc_i,
   input  logic [VLEN-1:0]        boot_addr_i,
   input  logic [PAD_W-1:0]       pad_i,
   input  logic                   time_irq_i,
   fence_t_sequencer_if.master    flush_if,
   output logic                   halt_o,
   output logic                   rst_uarch_no,
   output logic [VLEN-1:0]        rst_addr_o,
   output logic                   timeout_o,
   // Debug view of the FSM: 0 IDLE, 1 FLUSH, 2 DRAIN, 3 RST.
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2,
      RST   = 2'd3
   } state_e;

   localparam int unsigned RC_W = 8;
   localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [NR_CH-1:0]  mask_q, mask_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [VLEN-1:0]   rst_addr_q, rst_addr_d;
   logic [PAD_W-1:0]  pad_cnt_q;
   logic              time_irq_q;
   logic              expire;

   logic [NR_CH-1:0]  flush_req_q;
   logic              halt_q;
   logic              rst_uarch_nq;
   logic              timeout_q;

   // Next-state logic: sequence progression, ack mask, counters, resume address.
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      rst_cnt_d  = rst_cnt_q;
      to_cnt_d   = to_cnt_q;
      rst_addr_d = rst_addr_q;
      expire     = 1'b0;

      case (state_q)
         IDLE: begin
            to_cnt_d = '0;
            if (fence_t_i) begin
               state_d    = FLUSH;
               mask_d     = '0;
               // Wraps modulo 2^VLEN by construction.
               rst_addr_d = pc_i + VLEN'(4);
            end
         end
         FLUSH: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            mask_d   = mask_q | flush_if.flush_ack_i;
            if (&mask_d) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if ((flush_if.busy_i == '0) && (pad_cnt_q == '0)) begin
               state_d = RST;
            end
         end
         RST: begin
            if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
               state_d   = IDLE;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The limit covers the whole flush+drain window and overrides progress.
      if ((TIMEOUT != 0) && ((state_q == FLUSH) || (state_q == DRAIN)) &&
          (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
         expire  = 1'b1;
         state_d = RST;
      end
   end

   // State, counters and registered outputs derived from the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         rst_cnt_q    <= '0;
         to_cnt_q     <= '0;
         rst_addr_q   <= boot_addr_i;
         flush_req_q  <= '0;
         halt_q       <= 1'b0;
         rst_uarch_nq <= 1'b1;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         rst_cnt_q    <= rst_cnt_d;
         to_cnt_q     <= to_cnt_d;
         rst_addr_q   <= rst_addr_d;
         flush_req_q  <= (state_d == FLUSH) ? ~mask_d : '0;
         halt_q       <= (state_d != IDLE);
         rst_uarch_nq <= (state_d != RST);
         timeout_q    <= expire;
      end
   end

   // Pad counter: reload on every timer-interrupt rising edge, else count down to 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         time_irq_q <= 1'b0;
         pad_cnt_q  <= '0;
      end else begin
         time_irq_q <= time_irq_i;
         if (time_irq_i && !time_irq_q) begin
            pad_cnt_q <= pad_i;
         end else if (pad_cnt_q != '0) begin
            pad_cnt_q <= pad_cnt_q - PAD_W'(1);
         end
      end
   end

   assign flush_if.flush_req_o = flush_req_q;
   assign halt_o               = halt_q;
   assign rst_uarch_no         = rst_uarch_nq;
   assign rst_addr_o           = rst_addr_q;
   assign timeout_o            = timeout_q;
   assign state_o              = state_q;

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Bench for fence_t_sequencer: two instances (default limit and TIMEOUT=8)
// share one stimulus stream; a phase-level model predicts both every cycle,
// and directed scenarios pin literal values at hand-computed cycles.
module tb_fence_t_sequencer;

   localparam int unsigned VLEN = 64;
   localparam logic [VLEN-1:0] BOOT = 64'h0000_0000_0000_1000;

   // ---------------- clock / reset ----------------
   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic             rst;
   logic             fence;
   logic [VLEN-1:0]  pc;
   logic [VLEN-1:0]  boot;
   logic [31:0]      pad;
   logic             irq;
   logic [1:0]       ack;
   logic [1:0]       busy;

   fence_t_sequencer_if #(.NR_CH(2)) if0 ();
   fence_t_sequencer_if #(.NR_CH(2)) if1 ();
   assign if0.flush_ack_i = ack;
   assign if0.busy_i      = busy;
   assign if1.flush_ack_i = ack;
   assign if1.busy_i      = busy;

   logic            halt [2];
   logic            rstn [2];
   logic [VLEN-1:0] addr [2];
   logic            tout [2];
   logic [1:0]      state[2];
   logic [1:0]      fl   [2];
   assign fl[0] = if0.flush_req_o;
   assign fl[1] = if1.flush_req_o;

   fence_t_sequencer #(.NR_CH(2), .RST_CYCLES(16), .PAD_W(32), .TIMEOUT(1024), .VLEN(VLEN)) u_dut (
      .clk_i(clk), .rst_i(rst), .fence_t_i(fence), .pc_i(pc), .boot_addr_i(boot),
      .pad_i(pad), .time_irq_i(irq), .flush_if(if0.master), .halt_o(halt[0]),
      .rst_uarch_no(rstn[0]), .rst_addr_o(addr[0]), .timeout_o(tout[0]), .state_o(state[0])
   );

   fence_t_sequencer #(.NR_CH(2), .RST_CYCLES(16), .PAD_W(32), .TIMEOUT(8), .VLEN(VLEN)) u_dut_to (
      .clk_i(clk), .rst_i(rst), .fence_t_i(fence), .pc_i(pc), .boot_addr_i(boot),
      .pad_i(pad), .time_irq_i(irq), .flush_if(if1.master), .halt_o(halt[1]),
      .rst_uarch_no(rstn[1]), .rst_addr_o(addr[1]), .timeout_o(tout[1]), .state_o(state[1])
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 flushing, 2 draining, 3 in microreset
   bit              model_valid = 1'b0;
   int              m_phase  [2] = '{0, 0};
   int              m_acked  [2] = '{0, 0};
   int              m_left   [2] = '{0, 0};
   int              m_elapsed[2] = '{0, 0};
   longint unsigned m_pad    [2] = '{0, 0};
   bit              m_irqp   [2] = '{0, 0};
   logic [63:0]     m_addr   [2] = '{64'd0, 64'd0};
   bit              m_tpulse [2] = '{0, 0};

   task automatic model_step(input int k);
      int nxt;
      int tmo;
      tmo = (k == 0) ? 1024 : 8;
      m_tpulse[k] = 1'b0;
      if (rst) begin
         m_phase[k] = 0; m_acked[k] = 0; m_left[k] = 0; m_elapsed[k] = 0;
         m_pad[k] = 0; m_irqp[k] = 1'b0; m_addr[k] = boot;
         return;
      end
      nxt = m_phase[k];
      case (m_phase[k])
         0: begin
            m_elapsed[k] = 0;
            if (fence) begin
               nxt = 1;
               m_addr[k] = pc + 64'd4;
               m_acked[k] = 0;
            end
         end
         1: begin
            m_elapsed[k]++;
            m_acked[k] = m_acked[k] | int'(ack);
            if (m_acked[k] == 3) nxt = 2;
         end
         2: begin
            m_elapsed[k]++;
            if (busy == 2'b00 && m_pad[k] == 0) nxt = 3;
         end
         default: begin
            m_left[k]--;
            if (m_left[k] == 0) nxt = 0;
         end
      endcase
      if ((m_phase[k] == 1 || m_phase[k] == 2) && m_elapsed[k] >= tmo) begin
         nxt = 3;
         m_tpulse[k] = 1'b1;
      end
      if (nxt == 3 && m_phase[k] != 3) m_left[k] = 16;
      if (irq && !m_irqp[k]) m_pad[k] = longint'(pad);
      else if (m_pad[k] != 0) m_pad[k]--;
      m_irqp[k] = irq;
      m_phase[k] = nxt;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst) model_valid = 1'b1;
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // Every-cycle comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("u%0d flush_req", k), fl[k], (m_phase[k] == 1) ? (3 & ~m_acked[k]) : 0);
               chk($sformatf("u%0d halt", k), halt[k], m_phase[k] != 0);
               chk($sformatf("u%0d rst_uarch_n", k), rstn[k], m_phase[k] != 3);
               chk($sformatf("u%0d rst_addr", k), addr[k], m_addr[k]);
               chk($sformatf("u%0d timeout", k), tout[k], m_tpulse[k]);
               chk($sformatf("u%0d state", k), state[k], m_phase[k]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((halt[0] || halt[1]) && n < 100) begin
         step();
         n++;
      end
      n_checks++;
      if (halt[0] || halt[1]) begin
         n_errors++;
         $display("FAIL %s: still halted after %0d cycles, expected idle", name, n);
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      rst = 1'b1; fence = 1'b0; pc = '0; boot = BOOT; pad = '0; irq = 1'b0; ack = 2'b00; busy = 2'b00;
      step(); step();
      chk("reset halt", halt[0], 1'b0);
      chk("reset rst_n", rstn[0], 1'b1);
      chk("reset addr", addr[0], BOOT);
      chk("reset flush", fl[0], 2'b00);
      chk("reset timeout", tout[1], 1'b0);
      rst = 1'b0;
      step();

      // A: staggered acks, full timeline
      pc = 64'h8000_0100; fence = 1'b1; step(); fence = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         chk($sformatf("A flush c%0d", c), fl[0], (c <= 3) ? 2'b11 : (c <= 5) ? 2'b10 : 2'b00);
         chk($sformatf("A rst_n c%0d", c), rstn[0], !(c >= 7 && c <= 22));
         chk($sformatf("A halt c%0d", c), halt[0], c <= 22);
         chk($sformatf("A addr c%0d", c), addr[0], 64'h8000_0104);
         ack = (c == 3) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
         step();
      end
      ack = 2'b00;
      wait_idle("A idle");

      // B: both acks in the same cycle, repeated ack afterwards is ignored
      pc = 64'h100; fence = 1'b1; step(); fence = 1'b0;
      chk("B flush c1", fl[0], 2'b11);
      ack = 2'b11; step();
      chk("B state c2", state[0], 2);
      chk("B flush c2", fl[0], 2'b00);
      step();
      chk("B state c3", state[0], 3);
      chk("B flush c3", fl[0], 2'b00);
      ack = 2'b00;
      wait_idle("B idle");

      // C: pad counter from a timer edge in DRAIN, reloaded at count 3
      pad = 32'd10; busy = 2'b01;
      fence = 1'b1; step(); fence = 1'b0;
      ack = 2'b11; step(); ack = 2'b00;
      step();
      irq = 1'b1; step();
      irq = 1'b0; busy = 2'b00;
      for (int c = 4; c <= 23; c++) begin
         chk($sformatf("C state c%0d", c), state[0], (c <= 22) ? 2 : 3);
         if (c == 11) irq = 1'b1;
         step();
      end
      irq = 1'b0; pad = '0;
      wait_idle("C idle");

      // D: channel 1 never acks on the TIMEOUT=8 instance
      fence = 1'b1; step(); fence = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         chk($sformatf("D flush c%0d", c), fl[1], (c <= 2) ? 2'b11 : (c <= 8) ? 2'b10 : 2'b00);
         chk($sformatf("D timeout c%0d", c), tout[1], c == 9);
         chk($sformatf("D rst_n c%0d", c), rstn[1], !(c >= 9 && c <= 24));
         chk($sformatf("D halt c%0d", c), halt[1], c <= 24);
         ack = (c == 2) ? 2'b01 : (c == 26) ? 2'b10 : 2'b00;
         step();
      end
      ack = 2'b00;
      wait_idle("D idle");

      // E: fence.t in DRAIN ignored, reset in the 5th microreset cycle
      pc = 64'h2000; busy = 2'b01;
      fence = 1'b1; step(); fence = 1'b0;
      ack = 2'b11; step(); ack = 2'b00;
      step();
      fence = 1'b1; pc = 64'h3000; step(); fence = 1'b0; busy = 2'b00;
      chk("E state c4", state[0], 2);
      step();
      chk("E state c5", state[0], 3);
      step(); step(); step();
      chk("E addr c8", addr[0], 64'h2004);
      step();
      chk("E rst_n c9", rstn[0], 1'b0);
      rst = 1'b1; fence = 1'b1; step(); rst = 1'b0; fence = 1'b0;
      chk("E rst_n c10", rstn[0], 1'b1);
      chk("E halt c10", halt[0], 1'b0);
      chk("E addr c10", addr[0], BOOT);
      chk("E state c10", state[0], 0);
      step();

      // F: resume address wraps around
      pc = 64'hFFFF_FFFF_FFFF_FFFE; fence = 1'b1; step(); fence = 1'b0;
      chk("F addr", addr[0], 64'h2);
      chk("F halt", halt[0], 1'b1);
      ack = 2'b11; step(); ack = 2'b00;
      wait_idle("F idle");

      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fence_t_sequencer.md
FENCE_T_SEQUENCER -- requirements
Module: fence_t_sequencer

Interface
REQ-001 SHALL have parameter NR_CH, default 2: number of flush/ack channels (caches, TLBs), range 1..8.
REQ-002 SHALL have parameter RST_CYCLES, default 16: microreset pulse length in cycles, range 1..255.
REQ-003 SHALL have parameter PAD_W, default 32: pad counter width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: cycle limit for FLUSH plus DRAIN; 0 disables the limit.
REQ-005 SHALL have parameter VLEN, default riscv::VLEN: address width.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports clk_i (in, 1, rising-edge clock) and rst_i (in, 1, synchronous active-high reset).
REQ-007 SHALL have port fence_t_i, in, 1: fence.t commit pulse.
REQ-008 SHALL have port pc_i, in, VLEN: PC of the committing fence.t.
REQ-009 SHALL have port boot_addr_i, in, VLEN: resume address after reset.
REQ-010 SHALL have port pad_i, in, PAD_W: pad cycles relative to the time interrupt.
REQ-011 SHALL have port time_irq_i, in, 1: timer interrupt level.
REQ-012 SHALL have port flush_ack_i, in, NR_CH: per-channel flush done, single-cycle pulse.
REQ-013 SHALL have port busy_i, in, NR_CH: per-channel outstanding external transaction.
REQ-014 SHALL have port flush_req_o, out, NR_CH: per-channel flush request, level.
REQ-015 SHALL have port halt_o, out, 1: halts commit while the sequence runs.
REQ-016 SHALL have port rst_uarch_no, out, 1: active-low microreset.
REQ-017 SHALL have port rst_addr_o, out, VLEN: fetch address after microreset.
REQ-018 SHALL have port timeout_o, out, 1: one-cycle pulse when the flush/drain limit expires.

Function
REQ-019 SHALL use states IDLE, FLUSH, DRAIN, RST.
REQ-020 SHALL drive all outputs from registers only, with no combinational input-to-output path.
REQ-021 In IDLE, fence_t_i=1 SHALL cause: next state FLUSH; rst_addr_q <= pc_i+4; ack mask cleared; all flush_req_o bits 1 and halt_o 1 in the cycle after the pulse.
REQ-022 SHALL compute pc_i+4 modulo 2^VLEN, so wrap-around is allowed.
REQ-023 SHALL ignore fence_t_i in any state other than IDLE.
REQ-024 In FLUSH, flush_ack_i[i] SHALL set sticky mask bit i.
REQ-025 flush_req_o[i] SHALL drop in the cycle after its ack and stay low for the rest of the sequence.
REQ-026 SHALL ignore an ack on a channel already acked, and any ack received outside FLUSH.
REQ-027 FLUSH SHALL go to DRAIN on the edge where the mask, OR'ed with this cycle's acks, is all ones; simultaneous acks on all channels in one cycle are legal.
REQ-028 DRAIN SHALL go to RST when busy_i is all zeros and pad_cnt is 0, both in the same cycle.
REQ-029 pad_cnt SHALL load pad_i on a time_irq_i rising edge (time_irq_i=1 and its registered copy 0), in any state.
REQ-030 pad_cnt SHALL otherwise decrement by 1 while nonzero and saturate at 0.
REQ-031 A rising edge of time_irq_i while pad_cnt is nonzero SHALL reload pad_cnt.
REQ-032 In RST, rst_uarch_no SHALL be 0 for exactly RST_CYCLES consecutive cycles, after which the next state is IDLE.
REQ-033 The RST_CYCLES counter SHALL clear on exit from RST.
REQ-034 The timeout counter SHALL count cycles spent in FLUSH and DRAIN and clear in IDLE.
REQ-035 When TIMEOUT != 0 and the timeout count reaches TIMEOUT, the block SHALL pulse timeout_o for 1 cycle, drop all flush_req_o, and enter RST.
REQ-036 halt_o SHALL be 1 exactly when the state is not IDLE.
REQ-037 rst_addr_o SHALL hold its value outside the IDLE capture cycle.

Reset
REQ-038 On rst_i=1 at a clock edge, the block SHALL set: state IDLE; flush_req_o 0; halt_o 0; rst_uarch_no 1; timeout_o 0; pad_cnt 0; ack mask 0; all counters 0; rst_addr_o = boot_addr_i; registered time_irq 0.
REQ-039 Reset asserted mid-sequence, including during RST, SHALL abort the sequence at that edge, with rst_uarch_no 1 from the next cycle.
REQ-040 rst_i SHALL override every other input in the same cycle.

Verification
REQ-041 With NR_CH=2, pc_i=0x8000_0100, fence_t_i at cycle 0, acks ch0 at cycle 3 and ch1 at cycle 5, busy 0, pad 0, the bench SHALL check: rst_addr_o=0x8000_0104; flush_req_o=11 during cycles 1-3, 10 during cycles 4-5, then 00; rst_uarch_no low during cycles 7-22; halt_o low from cycle 23.
REQ-042 With both acks arriving in the same cycle as each other, the bench SHALL check a single FLUSH->DRAIN transition and no repeated flush request.
REQ-043 With pad_i=10, a time_irq_i rising edge during DRAIN, and busy clear, the bench SHALL check RST entry exactly 11 cycles after the edge, and that a second rising edge at count 3 reloads to 10.
REQ-044 With TIMEOUT=8 and ch1 never acking, the bench SHALL check timeout_o high for 1 cycle after 8 FLUSH cycles, flush_req_o=00, and then 16 reset cycles.
REQ-045 With rst_i asserted during the 5th RST cycle, the bench SHALL check rst_uarch_no=1, halt_o=0 and rst_addr_o=boot_addr_i on the next cycle, and that a fence_t_i during DRAIN is ignored.
REQ-046 With pc_i=all-ones minus 1, the bench SHALL check rst_addr_o=0x2, i.e. wrap-around.
